reset_request_gen: RTL



---
 rtl/reset_request_gen_pkg.sv | 21 ++
 rtl/reset_request_gen_if.sv | 25 ++
 rtl/pipeline_registers.sv | 34 +++
 rtl/reset_request_gen.sv | 129 ++++++++++++
 4 files changed

// File: rtl/reset_request_gen_pkg.sv
// Shared types and constants for the reset request generator.
// Holds the FSM state encoding and the bit layout of the sticky cause register.
package reset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  localparam int CAUSE_W   = 4;
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_WDT = 2;
  localparam int CAUSE_EXT = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_request_gen_if.sv
// Request/response bundle between reset sources and the reset request generator.
// The master side drives requests; the slave side is the generator itself.
interface reset_request_gen_if;
  import reset_pkg::*;

  logic               sw_req;
  logic               wdt_req;
  logic               ext_req_n;
  logic               cause_clr;
  logic               rst_n_req;
  logic               req_ack;
  logic               busy;
  logic [CAUSE_W-1:0] cause;

  modport master (
    output sw_req, wdt_req, ext_req_n, cause_clr,
    input  rst_n_req, req_ack, busy, cause
  );

  modport slave (
    input  sw_req, wdt_req, ext_req_n, cause_clr,
    output rst_n_req, req_ack, busy, cause
  );

endinterface

// File: rtl/pipeline_registers.sv
// Generic chain of resettable registers; also serves as a multi-flop synchronizer.
// Every stage loads RESET_VALUE while rst_n is low.
module pipeline_registers #(
  parameter int                   BIT_WIDTH        = 1,
  parameter int                   NUMBER_OF_STAGES = 2,
  parameter logic [BIT_WIDTH-1:0] RESET_VALUE      = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] data_in,
  output logic [BIT_WIDTH-1:0] data_out
);

  genvar gi;
  generate
    for (gi = 0; gi < NUMBER_OF_STAGES; gi++) begin : g_stage
      logic [BIT_WIDTH-1:0] q_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) q_reg <= RESET_VALUE;
          else        q_reg <= data_in;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) q_reg <= RESET_VALUE;
          else        q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign data_out = g_stage[NUMBER_OF_STAGES-1].q_reg;

endmodule

// File: rtl/reset_request_gen.sv
// Merges software, watchdog and external-pin reset requests into one stretched,
// flop-driven active-low reset pulse with power-on pulse, storm hold-off and cause log.
module reset_request_gen
  import reset_pkg::*;
#(
  parameter int PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clk,
  input  logic               rst_n_in,
  reset_request_gen_if.slave rr
);

  localparam int CNT_W = $clog2(max_int(PULSE_CYCLES, HOLDOFF_CYCLES) + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  =
      CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  state_e             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               rst_n_req_reg;
  logic               req_ack_reg;
  logic               busy_reg;
  logic [CAUSE_W-1:0] cause_reg;
  logic               pending_reg;
  logic               ext_prev_reg;

  logic               ext_sync;
  logic               ext_fall;
  logic               req_any;
  logic               trig;
  logic [CAUSE_W-1:0] set_bits;

  // The pin idles high, so the synchronizer resets to 1 to avoid a false edge.
  pipeline_registers #(
    .BIT_WIDTH        (1),
    .NUMBER_OF_STAGES (SYNC_STAGES),
    .RESET_VALUE      (1'b1)
  ) u_ext_sync (
    .clk      (clk),
    .rst_n    (rst_n_in),
    .data_in  (rr.ext_req_n),
    .data_out (ext_sync)
  );

  assign ext_fall = ext_prev_reg & ~ext_sync;
  assign req_any  = rr.sw_req | rr.wdt_req | ext_fall;
  assign trig     = req_any | pending_reg;

  always_comb begin
    set_bits            = '0;
    set_bits[CAUSE_SW]  = rr.sw_req;
    set_bits[CAUSE_WDT] = rr.wdt_req;
    set_bits[CAUSE_EXT] = ext_fall;
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg              <= ST_ASSERT;
      cnt_reg                <= '0;
      rst_n_req_reg          <= 1'b0;
      req_ack_reg            <= 1'b0;
      busy_reg               <= 1'b1;
      cause_reg              <= '0;
      cause_reg[CAUSE_POR]   <= 1'b1;
      pending_reg            <= 1'b0;
      ext_prev_reg           <= 1'b1;
    end else begin
      ext_prev_reg <= ext_sync;
      req_ack_reg  <= 1'b0;
      // A set landing with a clear wins for its own bit.
      cause_reg    <= (cause_reg & ~{CAUSE_W{rr.cause_clr}}) | set_bits;

      case (state_reg)
        ST_IDLE: begin
          if (trig) begin
            state_reg     <= ST_ASSERT;
            cnt_reg       <= '0;
            rst_n_req_reg <= 1'b0;
            req_ack_reg   <= 1'b1;
            busy_reg      <= 1'b1;
            pending_reg   <= 1'b0;
          end
        end

        ST_ASSERT: begin
          if (req_any) pending_reg <= 1'b1;
          if (cnt_reg == PULSE_LAST) begin
            cnt_reg       <= '0;
            rst_n_req_reg <= 1'b1;
            if (HOLDOFF_CYCLES == 0) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= ST_HOLDOFF;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        ST_HOLDOFF: begin
          if (req_any) pending_reg <= 1'b1;
          if (cnt_reg == HOLD_LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        default: begin
          state_reg     <= ST_ASSERT;
          cnt_reg       <= '0;
          rst_n_req_reg <= 1'b0;
          busy_reg      <= 1'b1;
        end
      endcase
    end
  end

  assign rr.rst_n_req = rst_n_req_reg;
  assign rr.req_ack   = req_ack_reg;
  assign rr.busy      = busy_reg;
  assign rr.cause     = cause_reg;

endmodule
